// File: rtl/ccr_branch_unit.sv
// Architectural condition-code register (Z/N/C) with jump evaluation, taken-jump flag clearing
// and a LIFO shadow stack for interrupt save/RTI. Optional macro: FLAG_BYPASS_EN.
module ccr_branch_unit #(
  parameter int         DEPTH     = 4,
  parameter logic [2:0] RESET_CCR = 3'b000,
  localparam int        LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_flag,
  input  logic [2:0]       flag_we,
  input  logic             jmp_valid,
  input  logic [1:0]       jmp_cond,
  input  logic             int_save,
  input  logic             rti_restore,
  output logic [2:0]       ccr,
  output logic             branch_taken,
  output logic [LVL_W-1:0] stack_level,
  output logic             stack_ovf,
  output logic             stack_unf
);

  localparam int               IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  logic [2:0]       stack_mem [DEPTH];
  logic [2:0]       written;
  logic [2:0]       eff;
  logic [2:0]       clr;
  logic [2:0]       ccr_upd;
  logic             stack_empty;
  logic             stack_full;
  logic             do_push;
  logic             do_pop;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;

  assign written = (flag_we & alu_flag) | (~flag_we & ccr);

`ifdef FLAG_BYPASS_EN
  // Jumps resolving alongside the flag-producing op see the new flags.
  assign eff = written;
`else
  assign eff = ccr;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    branch_taken = 1'b0;
    if (jmp_valid) begin
      case (jmp_cond)
        2'b00:   branch_taken = eff[0];
        2'b01:   branch_taken = eff[1];
        2'b10:   branch_taken = eff[2];
        default: branch_taken = 1'b1;
      endcase
    end
  end

  // Only the tested flag is cleared, and only when its jump is taken; JMP clears nothing.
  assign clr     = {3{branch_taken}} & {jmp_cond == 2'b10, jmp_cond == 2'b01, jmp_cond == 2'b00};
  assign ccr_upd = written & ~clr;

  assign stack_empty = (stack_level == '0);
  assign stack_full  = (stack_level == FULL_LEVEL);
  assign do_pop      = rti_restore && !stack_empty;
  assign do_push     = int_save && !rti_restore && !stack_full;
  assign push_idx    = stack_level[IDX_W-1:0];
  assign top_idx     = IDX_W'(stack_level - 1'b1);

  // NOTE: shadow entries carry no reset; stack_level alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[push_idx] <= ccr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccr         <= RESET_CCR;
      stack_level <= '0;
      stack_ovf   <= 1'b0;
      stack_unf   <= 1'b0;
    end else begin
      ccr <= do_pop ? stack_mem[top_idx] : ccr_upd;
      if (do_pop)       stack_level <= stack_level - 1'b1;
      else if (do_push) stack_level <= stack_level + 1'b1;
      if (int_save && !rti_restore && stack_full) stack_ovf <= 1'b1;
      if (rti_restore && stack_empty)             stack_unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccr_branch_unit.sv
// Scoreboard bench for ccr_branch_unit: a queue-based reference model predicts branch_taken
// each cycle and pushes the expected post-edge state, which a monitor pops and compares.
module tb_ccr_branch_unit;

  localparam int         DEPTH = 4;
  localparam int         LW    = $clog2(DEPTH + 1);
  localparam logic [2:0] RCCR  = 3'b000;

  typedef struct {
    string      tag;
    logic [2:0] ccr;
    int         level;
    logic       ovf;
    logic       unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    alu_flag = '0;
  logic [2:0]    flag_we = '0;
  logic          jmp_valid = 1'b0;
  logic [1:0]    jmp_cond = '0;
  logic          int_save = 1'b0;
  logic          rti_restore = 1'b0;
  logic [2:0]    ccr;
  logic          branch_taken;
  logic [LW-1:0] stack_level;
  logic          stack_ovf;
  logic          stack_unf;

  exp_t       sb_q[$];
  logic [2:0] m_stack[$];
  logic [2:0] m_ccr = RCCR;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  int         checks = 0;
  int         errors = 0;

  ccr_branch_unit #(.DEPTH(DEPTH), .RESET_CCR(RCCR)) dut (
    .clk(clk), .rst(rst), .alu_flag(alu_flag), .flag_we(flag_we),
    .jmp_valid(jmp_valid), .jmp_cond(jmp_cond), .int_save(int_save),
    .rti_restore(rti_restore), .ccr(ccr), .branch_taken(branch_taken),
    .stack_level(stack_level), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, check the combinational decision, predict the next state.
  task automatic step(input string tag, input logic r, input logic [2:0] we, input logic [2:0] af,
                      input logic jv, input logic [1:0] jc, input logic sv, input logic rt);
    logic [2:0] w;
    logic [2:0] eff;
    logic [2:0] clr;
    logic       tk;
    exp_t       e;
    @(negedge clk);
    rst = r; flag_we = we; alu_flag = af; jmp_valid = jv; jmp_cond = jc;
    int_save = sv; rti_restore = rt;
    #1;
    w = (we & af) | (~we & m_ccr);
`ifdef FLAG_BYPASS_EN
    eff = w;
`else
    eff = m_ccr;
`endif
    tk = 1'b0;
    if (jv) tk = (jc == 2'b11) ? 1'b1 : eff[jc];
    check({tag, ".taken"}, 32'(branch_taken), 32'(tk));
    clr = 3'b000;
    if (tk && jc != 2'b11) clr[jc] = 1'b1;
    if (r) begin
      m_ccr = RCCR;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (rt && m_stack.size() > 0) begin
      m_ccr = m_stack.pop_back();
    end else begin
      if (sv && !rt) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_ccr);
        else m_ovf = 1'b1;
      end
      if (rt) m_unf = 1'b1;
      m_ccr = w & ~clr;
    end
    e.tag = tag; e.ccr = m_ccr; e.level = m_stack.size(); e.ovf = m_ovf; e.unf = m_unf;
    sb_q.push_back(e);
  endtask

  // Monitor: the registered outputs after each edge are matched against the oldest prediction.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, ".ccr"},   32'(ccr),         32'(e.ccr));
      check({e.tag, ".level"}, 32'(stack_level), 32'(e.level));
      check({e.tag, ".ovf"},   32'(stack_ovf),   32'(e.ovf));
      check({e.tag, ".unf"},   32'(stack_unf),   32'(e.unf));
    end
  end

  initial begin
    step("reset",      1, 3'b000, 3'b000, 0, 2'b00, 0, 0);
    step("add_zero",   0, 3'b001, 3'b001, 0, 2'b00, 0, 0);
    step("jz_taken",   0, 3'b000, 3'b000, 1, 2'b00, 0, 0);
    step("jn_not",     0, 3'b000, 3'b000, 1, 2'b01, 0, 0);
    step("jmp",        0, 3'b000, 3'b000, 1, 2'b11, 0, 0);
    step("bypass_jc",  0, 3'b100, 3'b100, 1, 2'b10, 0, 0);
    step("clr_c",      0, 3'b100, 3'b000, 0, 2'b00, 0, 0);
    step("set_n",      0, 3'b010, 3'b010, 0, 2'b00, 0, 0);
    step("jn_wr_z",    0, 3'b001, 3'b001, 1, 2'b01, 0, 0);
    step("set_101",    0, 3'b111, 3'b101, 0, 2'b00, 0, 0);
    step("save_1",     0, 3'b000, 3'b000, 0, 2'b00, 1, 0);
    step("set_010",    0, 3'b111, 3'b010, 0, 2'b00, 0, 0);
    step("save_2",     0, 3'b000, 3'b000, 0, 2'b00, 1, 0);
    step("rti_1",      0, 3'b111, 3'b111, 1, 2'b00, 0, 1);
    step("rti_2",      0, 3'b000, 3'b000, 0, 2'b00, 0, 1);
    step("save_wr",    0, 3'b011, 3'b011, 0, 2'b00, 1, 0);
    step("save_rti",   0, 3'b000, 3'b000, 0, 2'b00, 1, 1);
    step("reset2",     1, 3'b000, 3'b000, 0, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++)
      step("push_ovf", 0, 3'b111, 3'(i), 0, 2'b00, 1, 0);
    step("rst_mid",    1, 3'b111, 3'b111, 1, 2'b00, 1, 1);
    step("set_011",    0, 3'b111, 3'b011, 0, 2'b00, 0, 0);
    step("rti_unf",    0, 3'b000, 3'b000, 0, 2'b00, 0, 1);
    step("unf_sticky", 0, 3'b000, 3'b000, 0, 2'b00, 1, 0);
    step("reset3",     1, 3'b000, 3'b000, 0, 2'b00, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 39) == 0), 3'($urandom), 3'($urandom),
           1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccr_branch_unit.md
Name: ccr_branch_unit

Overview:
- Consumer end of the EX-stage flag interface. Holds the architectural condition-code register (CCR: bit0 Z, bit1 N, bit2 C).
- Writes the CCR from per-bit flag updates produced in EX.
- Evaluates conditional jumps (JZ/JN/JC/JMP) for the branch path and clears the tested flag when a conditional jump is taken.
- Saves/restores the CCR on interrupt entry/RTI through a small shadow stack.

Parameters:
- DEPTH, 4, number of shadow-stack entries for nested interrupt saves (>=1).
- RESET_CCR, 3'b000, CCR value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- alu_flag  input  3  flag values from EX ({C,N,Z}).
- flag_we  input  3  per-bit write enable for alu_flag (EX asserts only the bits the op updates).
- jmp_valid  input  1  a jump instruction is being resolved this cycle.
- jmp_cond  input  2  00 JZ, 01 JN, 10 JC, 11 JMP (unconditional).
- int_save  input  1  push current CCR to the shadow stack (interrupt entry).
- rti_restore  input  1  pop the shadow stack into the CCR (RTI).
- ccr  output  3  registered CCR.
- branch_taken  output  1  combinational jump decision.
- stack_level  output  $clog2(DEPTH+1)  number of occupied shadow entries.
- stack_ovf  output  1  sticky: push attempted while full.
- stack_unf  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst high at edge): ccr=RESET_CCR, stack_level=0, stack_ovf=0, stack_unf=0; shadow contents don't-care. Reset overrides every other input in that cycle, including a mid-operation save/restore.
- Effective flags for branch evaluation: eff = ccr (macro off) or bypassed value (see Optional Feature).
- branch_taken = jmp_valid & (cond==11 | eff[cond]); zero latency (combinational); 0 when jmp_valid=0.
- Clear mask: clr[i]=1 iff jmp_valid, jmp_cond==i (i in 0..2), and the jump is taken. JMP never clears.
- CCR next state, no restore: per bit, w = flag_we[i] ? alu_flag[i] : ccr[i]; ccr_next[i] = w & ~clr[i]. A clear therefore wins over a same-cycle write of the same bit; writes to other bits are unaffected.
- Restore: if rti_restore and stack_level>0, ccr_next = top entry, stack_level decrements. The restore overrides flag_we and clr completely.
- Restore with stack empty: ccr follows the no-restore rule, stack_level stays 0, stack_unf set.
- Save: if int_save and stack_level<DEPTH, push the current registered ccr (the pre-edge value, not ccr_next), stack_level increments. flag_we/clr still update ccr normally that cycle.
- Save with stack full: no push, stack unchanged, stack_ovf set.
- int_save and rti_restore in the same cycle: restore is performed, save is ignored, and neither error is set unless the restore itself underflows.
- Stack is LIFO: the entry pushed last is restored first; no wrap-around.
- stack_ovf and stack_unf clear only on reset.
- Single cycle throughput; no stall input; every input is sampled each cycle.

Optional Feature:
- Macro FLAG_BYPASS_EN.
- Defined: eff[i] = flag_we[i] ? alu_flag[i] : ccr[i], so a jump resolving in the same cycle as the flag-producing op sees the new flag.
- Undefined: eff = ccr. The jump sees only the registered flags, one cycle behind EX; the pipeline must insert a bubble.
- Clear and priority rules are identical in both builds.

Test Plan:
- Reset then ADD result zero: flag_we=3'b001, alu_flag=3'b001 -> next cycle ccr=001; JZ (jmp_valid=1, cond=00) -> branch_taken=1, following cycle ccr=000.
- ccr=000 with JN -> branch_taken=0, ccr unchanged.
- JMP (cond=11) with ccr=000 -> branch_taken=1, ccr unchanged.
- Bypass: ccr=000, same cycle flag_we=100, alu_flag=100, JC -> branch_taken=1 with FLAG_BYPASS_EN, 0 without. Next ccr=000 with the macro (clear wins), 100 without.
- Nesting: ccr=101, int_save; then ccr set to 010, int_save; then two rti_restore -> ccr=010 then 101, stack_level 2->1->0.
- Errors: DEPTH=4, five int_save -> stack_level=4, stack_ovf=1. After reset, rti_restore with ccr=011 -> ccr=011, stack_unf=1. Assert rst mid-sequence -> all outputs return to reset values on the next edge.
